// File: rtl/cache_ctrl_pkg.sv
// Shared types for the N-way cache controller: FSM states,
// counter width and a lowest-set-bit priority encoder.
package cache_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOC_TAG,
    ALLOC_FILL,
    FL_READ,
    FL_CHECK,
    FL_WB,
    FL_DONE
  } state_e;

  localparam int PERF_CNT_W = 32;
  localparam int MAX_WAYS   = 64;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned onehot_to_idx(
    input logic [MAX_WAYS-1:0] v
  );
    onehot_to_idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) onehot_to_idx = i;
    end
  endfunction

endpackage

// File: rtl/cache_flush_walker.sv
// Set/way cursor for the clean-all flush walk.
// clr_i zeroes, inc_i steps way (carrying into set); wraps flag ends.
module cache_flush_walker
  import cache_ctrl_pkg::*;
#(
  parameter  int NUM_WAYS = 8,
  parameter  int SET_W    = 3,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [SET_W-1:0] set_o,
  output logic [WAY_W-1:0] way_o,
  output logic             way_wrap_o,
  output logic             set_wrap_o
);

  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;

  assign set_o      = set_q;
  assign way_o      = way_q;
  assign way_wrap_o = &way_q;
  assign set_wrap_o = &set_q;

  // Both counters are powers of two, so plain
  // increment wraps them back to zero after the last set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q <= '0;
      way_q <= '0;
    end else if (clr_i) begin
      set_q <= '0;
      way_q <= '0;
    end else if (inc_i) begin
      way_q <= way_q + 1'b1;
      if (way_wrap_o) set_q <= set_q + 1'b1;
    end
  end

endmodule

// File: rtl/nway_cache_control.sv
// nway_cache_control: control FSM of an N-way set-associative
// write-back, write-allocate cache with a clean-all flush walk.
// Ports: mem_* upstream handshake, pmem_* lower-level handshake,
// flush_* flush control/cursor, way_hit/valid/dirty/plru in from
// the datapath, tag/valid/dirty/data/lru strobes out to the arrays.
// Build option CACHE_PERF_CNT_EN adds hit/miss/writeback counters.
module nway_cache_control
  import cache_ctrl_pkg::*;
#(
  parameter  int NUM_WAYS = 8,
  parameter  int SET_W    = 3,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  output logic                mem_resp_o,
  input  logic                flush_req_i,
  output logic                flush_done_o,
  output logic                flush_active_o,
  output logic [SET_W-1:0]    flush_set_o,
  output logic                pmem_read_o,
  output logic                pmem_write_o,
  input  logic                pmem_resp_i,
  output logic                pmem_addr_sel_o,
  input  logic [NUM_WAYS-1:0] way_hit_i,
  input  logic [NUM_WAYS-1:0] valid_out_i,
  input  logic [NUM_WAYS-1:0] dirty_out_i,
  input  logic [WAY_W-1:0]    plru_way_i,
  output logic [NUM_WAYS-1:0] tag_load_o,
  output logic                valid_load_o,
  output logic                dirty_load_o,
  output logic [NUM_WAYS-1:0] valid_in_o,
  output logic [NUM_WAYS-1:0] dirty_in_o,
  output logic                lru_load_o,
  output logic [WAY_W-1:0]    mru_o,
  output logic [WAY_W-1:0]    way_sel_o,
  output logic                way_data_in_sel_o,
  output logic [NUM_WAYS-1:0] data_write_en_o
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] hit_count_o,
  output logic [PERF_CNT_W-1:0] miss_count_o,
  output logic [PERF_CNT_W-1:0] wb_count_o
`endif
);

  state_e state_q, state_d, adv_st;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] hit_idx, way_cnt;
  logic [NUM_WAYS-1:0] vic_oh;
  logic req_rd, req_wr, req_one, hit;
  logic vic_dirty, cnt_dirty;
  logic way_wrap, set_wrap;
  logic walk_inc, walk_clr;

  assign req_rd  = mem_read_i & ~mem_write_i;
  assign req_wr  = mem_write_i & ~mem_read_i;
  assign req_one = req_rd | req_wr;
  assign hit     = |way_hit_i;
  assign hit_idx =
    WAY_W'(onehot_to_idx(MAX_WAYS'(way_hit_i)));
  assign vic_oh  = NUM_WAYS'(1) << victim_q;

  assign vic_dirty = valid_out_i[plru_way_i]
                   & dirty_out_i[plru_way_i];
  assign cnt_dirty = valid_out_i[way_cnt]
                   & dirty_out_i[way_cnt];

  cache_flush_walker #(
    .NUM_WAYS (NUM_WAYS),
    .SET_W    (SET_W)
  ) u_walk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (walk_clr),
    .inc_i      (walk_inc),
    .set_o      (flush_set_o),
    .way_o      (way_cnt),
    .way_wrap_o (way_wrap),
    .set_wrap_o (set_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    mem_resp_o        = 1'b0;
    flush_done_o      = 1'b0;
    pmem_read_o       = 1'b0;
    pmem_write_o      = 1'b0;
    pmem_addr_sel_o   = 1'b0;
    tag_load_o        = '0;
    valid_load_o      = 1'b0;
    dirty_load_o      = 1'b0;
    valid_in_o        = valid_out_i;
    dirty_in_o        = dirty_out_i;
    lru_load_o        = 1'b0;
    mru_o             = hit_idx;
    way_sel_o         = hit_idx;
    way_data_in_sel_o = 1'b0;
    data_write_en_o   = '0;
    walk_inc          = 1'b0;
    walk_clr          = 1'b0;
    // Where the walk goes once the current way is done.
    adv_st = way_wrap ? (set_wrap ? FL_DONE : FL_READ)
                      : FL_CHECK;

    unique case (state_q)
      IDLE: begin
        if (flush_req_i && !(mem_read_i || mem_write_i)) begin
          state_d  = FL_READ;
          walk_clr = 1'b1;
        end else begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!req_one) begin
          state_d = IDLE;
        end else if (hit) begin
          mem_resp_o = 1'b1;
          lru_load_o = 1'b1;
          if (req_wr) begin
            dirty_load_o          = 1'b1;
            dirty_in_o[hit_idx]   = 1'b1;
            data_write_en_o       = way_hit_i;
            way_data_in_sel_o     = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = plru_way_i;
          state_d  = vic_dirty ? WRITE_BACK : ALLOC_TAG;
        end
      end
      WRITE_BACK: begin
        pmem_write_o    = 1'b1;
        pmem_addr_sel_o = 1'b1;
        way_sel_o       = victim_q;
        if (pmem_resp_i) state_d = ALLOC_TAG;
      end
      ALLOC_TAG: begin
        tag_load_o           = vic_oh;
        valid_load_o         = 1'b1;
        dirty_load_o         = 1'b1;
        valid_in_o[victim_q] = 1'b1;
        dirty_in_o[victim_q] = 1'b0;
        lru_load_o           = 1'b1;
        mru_o                = victim_q;
        state_d              = ALLOC_FILL;
      end
      ALLOC_FILL: begin
        // Return to IDLE so the request re-compares and hits.
        pmem_read_o     = 1'b1;
        data_write_en_o = vic_oh;
        if (pmem_resp_i) state_d = IDLE;
      end
      FL_READ: begin
        state_d = FL_CHECK;
      end
      FL_CHECK: begin
        if (cnt_dirty) begin
          state_d = FL_WB;
        end else begin
          walk_inc = 1'b1;
          state_d  = adv_st;
        end
      end
      FL_WB: begin
        pmem_write_o    = 1'b1;
        pmem_addr_sel_o = 1'b1;
        way_sel_o       = way_cnt;
        if (pmem_resp_i) begin
          dirty_load_o        = 1'b1;
          dirty_in_o[way_cnt] = 1'b0;
          walk_inc            = 1'b1;
          state_d             = adv_st;
        end
      end
      FL_DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_active_o = (state_q == FL_READ)
                        | (state_q == FL_CHECK)
                        | (state_q == FL_WB)
                        | (state_q == FL_DONE);

  // Multi-hot tags point at datapath corruption; lowest way wins.
  mh_hit_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == COMPARE) |-> $onehot0(way_hit_i)
  );

`ifdef CACHE_PERF_CNT_EN
  logic hit_ev, miss_ev, wb_ev;
  logic [PERF_CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  assign hit_ev  = (state_q == COMPARE) & req_one & hit;
  assign miss_ev = (state_q == COMPARE) & req_one & ~hit;
  assign wb_ev   = ((state_q == WRITE_BACK)
                 | (state_q == FL_WB)) & pmem_resp_i;

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
  assign wb_count_o   = wb_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_ev && !(&hit_cnt_q))
        hit_cnt_q <= hit_cnt_q + 1'b1;
      if (miss_ev && !(&miss_cnt_q))
        miss_cnt_q <= miss_cnt_q + 1'b1;
      if (wb_ev && !(&wb_cnt_q))
        wb_cnt_q <= wb_cnt_q + 1'b1;
    end
  end
`endif

endmodule
